// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the dual-port RAM port-2 arbiter.
//   arb_state_e : FSM state encoding (IDLE = 0, GRANT = 1)
//   WIN_W       : address bits that select a requester window
//   CNT_W       : burst counter width
//   ptr_width() : index width for an n-entry requester vector
package dpram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned WIN_W = 3;
    localparam int unsigned CNT_W = 8;

    // Index width, never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req    in  NREQ : request vector
//   ptr    in  PW   : index of the last winner; search starts at ptr+1
//   gnt_c  out NREQ : one-hot winner, 0 when no request is set
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PW  = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_c
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk ptr+1 .. ptr+NREQ modulo NREQ; first set bit wins.
    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of RAM port 2 among NREQ cores.
// A winner holds a locked grant for a burst of single-cycle accesses; the
// grant is released when its req drops, or after MAX_BURST accesses if any
// other core is waiting.
//   clk, rst_n            : clock, async active-low reset
//   req/rd_r/wr_r         : per-requester request level and access strobes
//   addr_r/wdata_r        : packed per-requester address / write data
//   gnt, ack, err         : registered one-hot grant, access ack, window error
//   rdata                 : read data, valid with a read ack, held otherwise
//   addr_2,d_in_2,rd_2,wr_2,d_out_2 : RAM port-2 interface
// Optional build macro DPRAM_ARB_WINDOW_EN: requester i may only touch
// addresses whose top 3 bits equal i; violations are suppressed and flagged
// on err instead of ack.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    rd_r,
    input  logic [NREQ-1:0]    wr_r,
    input  logic [NREQ*AW-1:0] addr_r,
    input  logic [NREQ*DW-1:0] wdata_r,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [NREQ-1:0]    err,
    output logic [AW-1:0]      addr_2,
    output logic [DW-1:0]      d_in_2,
    output logic               rd_2,
    output logic               wr_2,
    input  logic [DW-1:0]      d_out_2
);

    localparam int unsigned    PW        = ptr_width(NREQ);
    localparam logic [CNT_W:0] CNT_ONE   = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  gnt_d, ack_d, pick_c, others_c;
    logic [PW-1:0]    ptr_q, ptr_d, pick_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_rd, sel_wr, sel_req;
    logic             access, in_win, issue, rd_issue;
    logic             rd_ack_q;
    logic [DW-1:0]    rdata_q;

    // Round-robin winner for the next grant.
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt_c (pick_c)
    );

    // One-hot winner to index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_c[i]) pick_idx = PW'(i);
        end
    end

    // Select the granted requester's signals; ptr holds the current owner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_req   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ptr_q == PW'(i)) begin
                sel_addr  = addr_r[i*AW +: AW];
                sel_wdata = wdata_r[i*DW +: DW];
                sel_rd    = rd_r[i];
                sel_wr    = wr_r[i];
                sel_req   = req[i];
            end
        end
    end

    // An access is any strobe from the owner; it is issued only when in-window.
    assign access = (state_q == GRANT) && (sel_rd || sel_wr);

`ifdef DPRAM_ARB_WINDOW_EN
    assign in_win = (sel_addr[AW-1 -: WIN_W] == WIN_W'(ptr_q));
`else
    assign in_win = 1'b1;
`endif

    assign issue    = access && in_win;
    assign rd_issue = issue && sel_rd && !sel_wr;   // write wins over read
    assign rd_2     = rd_issue;
    assign wr_2     = issue && sel_wr;
    assign addr_2   = issue ? sel_addr  : '0;
    assign d_in_2   = issue ? sel_wdata : '0;

    assign cnt_inc  = {1'b0, cnt_q} + CNT_ONE;
    assign others_c = req & ~gnt;

    // RAM read data arrives in the ack cycle; hold it until the next read.
    assign rdata = rd_ack_q ? d_out_2 : rdata_q;

    // Next-state, grant, counter and ack logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = issue ? gnt : '0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = pick_c;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (access) begin
                    cnt_d = (cnt_inc >= BURST_LIM) ? BURST_LIM[CNT_W-1:0]
                                                   : cnt_inc[CNT_W-1:0];
                end
                // Burst limit applies only when someone else is waiting.
                if (!sel_req || (access && (cnt_inc >= BURST_LIM) && (|others_c))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt      <= '0;
            ptr_q    <= PW'(NREQ - 1);
            cnt_q    <= '0;
            ack      <= '0;
            rd_ack_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ack      <= ack_d;
            rd_ack_q <= rd_issue;
            rdata_q  <= rdata;
        end
    end

`ifdef DPRAM_ARB_WINDOW_EN
    // Window violation pulse, one cycle after the suppressed access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err <= (access && !in_win) ? gnt : '0;
        end
    end
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed stimulus, a cycle-level arbiter
// model with its own memory image, and a bench-side RAM behind port 2.
// Honours DPRAM_ARB_WINDOW_EN when the design is built with it.
module tb_dpram_port_arbiter;

    localparam int NREQ = 4;
    localparam int MAXB = 8;
    localparam int AW   = 8;
    localparam int DW   = 16;

`ifdef DPRAM_ARB_WINDOW_EN
    localparam logic [AW-1:0] T1A = 8'h30;
`else
    localparam logic [AW-1:0] T1A = 8'h10;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req, rd_r, wr_r;
    logic [NREQ*AW-1:0] addr_r;
    logic [NREQ*DW-1:0] wdata_r;
    logic [NREQ-1:0]    gnt, ack, err;
    logic [DW-1:0]      rdata, d_in_2, d_out_2;
    logic [AW-1:0]      addr_2;
    logic               rd_2, wr_2;

    int checks   = 0;
    int failures = 0;

    dpram_port_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rd_r(rd_r), .wr_r(wr_r),
        .addr_r(addr_r), .wdata_r(wdata_r), .gnt(gnt), .ack(ack),
        .rdata(rdata), .err(err), .addr_2(addr_2), .d_in_2(d_in_2),
        .rd_2(rd_2), .wr_2(wr_2), .d_out_2(d_out_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench RAM behind port 2: registered read, cleared on reset.
    logic [DW-1:0] ram [256];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            d_out_2 <= '0;
        end else begin
            if (rd_2) d_out_2 <= ram[addr_2];
            if (wr_2) ram[addr_2] <= d_in_2;
        end
    end

    // Arbiter model: owner index (-1 = none), last winner, burst count.
    int            m_owner, m_ptr, m_cnt;
    logic [NREQ-1:0] m_gnt, m_ack, m_err;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_mem [256];

    always @(posedge clk or negedge rst_n) begin
        int  w, c;
        bit  found, acc, inwin, others;
        logic [AW-1:0] a;
        if (!rst_n) begin
            m_owner = -1; m_ptr = NREQ - 1; m_cnt = 0;
            m_gnt = '0; m_ack = '0; m_err = '0; m_rdata = '0;
            for (int i = 0; i < 256; i++) m_mem[i] = '0;
        end else begin
            m_ack = '0;
            m_err = '0;
            if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (!found && req[c]) begin
                        found = 1; m_owner = c; m_ptr = c; m_cnt = 0;
                    end
                end
            end else begin
                w   = m_owner;
                a   = addr_r[w*AW +: AW];
                acc = rd_r[w] || wr_r[w];
`ifdef DPRAM_ARB_WINDOW_EN
                inwin = (int'(a[AW-1:AW-3]) == w);
`else
                inwin = 1;
`endif
                if (acc) begin
                    if (inwin) begin
                        m_ack[w] = 1'b1;
                        if (wr_r[w]) m_mem[a] = wdata_r[w*DW +: DW];
                        else         m_rdata  = m_mem[a];
                    end else begin
                        m_err[w] = 1'b1;
                    end
                    m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
                end
                others = 0;
                for (int i = 0; i < NREQ; i++) if (i != w && req[i]) others = 1;
                if (!req[w] || (acc && m_cnt >= MAXB && others)) m_owner = -1;
            end
            m_gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        end
    end

    // Per-cycle compare against the model; also logs new grants in order.
    int               gnt_order [$];
    logic [NREQ-1:0]  prev_gnt = '0;
    always @(negedge clk) begin
        int            w;
        logic          e_rd, e_wr, inwin;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        if (rst_n === 1'b1) begin
            e_rd = 0; e_wr = 0; e_addr = '0; e_din = '0;
            if (m_owner >= 0) begin
                w = m_owner;
`ifdef DPRAM_ARB_WINDOW_EN
                inwin = (int'(addr_r[w*AW+AW-1 -: 3]) == w);
`else
                inwin = 1;
`endif
                if ((rd_r[w] || wr_r[w]) && inwin) begin
                    e_wr   = wr_r[w];
                    e_rd   = rd_r[w] && !wr_r[w];
                    e_addr = addr_r[w*AW +: AW];
                    e_din  = wdata_r[w*DW +: DW];
                end
            end
            check("cyc_gnt",    32'(gnt),    32'(m_gnt));
            check("cyc_ack",    32'(ack),    32'(m_ack));
            check("cyc_err",    32'(err),    32'(m_err));
            check("cyc_rdata",  32'(rdata),  32'(m_rdata));
            check("cyc_rd_2",   32'(rd_2),   32'(e_rd));
            check("cyc_wr_2",   32'(wr_2),   32'(e_wr));
            check("cyc_addr_2", 32'(addr_2), 32'(e_addr));
            check("cyc_d_in_2", 32'(d_in_2), 32'(e_din));
            if (gnt != '0 && gnt != prev_gnt) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_order.push_back(i);
            end
            prev_gnt = gnt;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clear_all;
        req = '0; rd_r = '0; wr_r = '0; addr_r = '0; wdata_r = '0;
    endtask

    task automatic set_acc(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd_r[i] = rd;
        wr_r[i] = wr;
        addr_r[i*AW +: AW]  = a;
        wdata_r[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        clear_all();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input logic [NREQ-1:0] e, input int budget, input string nm);
        int n = 0;
        while (gnt !== e && n < budget) begin tick(); n++; end
        check(nm, 32'(gnt), 32'(e));
    endtask

    initial begin
        int base, n, cnt0, lost;
        rst_n = 1'b0;
        clear_all();

        // Reset state and single requester write/write/read.
        do_reset();
        check("reset_gnt",   32'(gnt),   32'h0);
        check("reset_ack",   32'(ack),   32'h0);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_wr_2",  32'(wr_2),  32'h0);
        req = 4'b0010;
        tick();
        check("t1_gnt", 32'(gnt), 32'h2);
        set_acc(1, 1'b0, 1'b1, T1A, 16'hBEEF);
        tick();
        check("t1_ack_wr0", 32'(ack), 32'h2);
        set_acc(1, 1'b0, 1'b1, T1A + 8'd1, 16'hCAFE);
        tick();
        check("t1_ack_wr1", 32'(ack), 32'h2);
        set_acc(1, 1'b1, 1'b0, T1A, 16'h0);
        tick();
        check("t1_ack_rd",  32'(ack),   32'h2);
        check("t1_rdata",   32'(rdata), 32'hBEEF);
        set_acc(1, 1'b0, 1'b0, '0, '0);
        req = '0;
        tick();
        check("t1_release", 32'(gnt), 32'h0);

        // All four request at once from reset: order 0,1,2,3.
        do_reset();
        base = gnt_order.size();
        for (int i = 0; i < NREQ; i++) set_acc(i, 1'b1, 1'b0, AW'(i * 32), '0);
        req = 4'b1111;
        n = 0;
        while (gnt_order.size() < base + 4 && n < 80) begin tick(); n++; end
        check("rr_count", 32'(gnt_order.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (gnt_order.size() > base + k) check("rr_order", 32'(gnt_order[base+k]), 32'(k));
        end
        clear_all();
        tick(); tick();

        // Burst limit against a waiting requester, then an unlimited lone burst.
        do_reset();
        set_acc(0, 1'b1, 1'b0, 8'h00, '0);
        req  = 4'b0101;
        cnt0 = 0;
        n    = 0;
        while (n < 40) begin
            tick(); n++;
            if (ack[0]) cnt0++;
            if (gnt == 4'b0100) break;
        end
        check("burst_acks",     32'(cnt0), 32'd8);
        check("burst_next_gnt", 32'(gnt),  32'h4);
        req = 4'b0001;
        wait_gnt(4'b0001, 10, "lone_gnt");
        cnt0 = 0;
        lost = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ack[0]) cnt0++;
            if (gnt != 4'b0001) lost++;
        end
        check("lone_acks", 32'(cnt0), 32'd20);
        check("lone_held", 32'(lost), 32'd0);
        clear_all();
        tick(); tick();

        // Simultaneous read and write: write wins.
        req = 4'b0010;
        wait_gnt(4'b0010, 10, "rw_gnt");
        set_acc(1, 1'b1, 1'b1, 8'h20, 16'h1234);
        #1;
        check("rw_wr_2",   32'(wr_2),   32'h1);
        check("rw_rd_2",   32'(rd_2),   32'h0);
        check("rw_addr_2", 32'(addr_2), 32'h20);
        tick();
        check("rw_ack_wr", 32'(ack), 32'h2);
        set_acc(1, 1'b1, 1'b0, 8'h20, '0);
        tick();
        check("rw_ack_rd", 32'(ack),   32'h2);
        check("rw_rdata",  32'(rdata), 32'h1234);

        // Asynchronous reset in the middle of a read stream.
        tick();
        check("mid_ack_live", 32'(ack), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt",  32'(gnt),  32'h0);
        check("arst_ack",  32'(ack),  32'h0);
        check("arst_rd_2", 32'(rd_2), 32'h0);
        check("arst_wr_2", 32'(wr_2), 32'h0);
        clear_all();
        tick();
        rst_n = 1'b1;
        req = 4'b0011;
        tick();
        check("arst_regrant", 32'(gnt), 32'h1);
        clear_all();
        tick(); tick();

`ifdef DPRAM_ARB_WINDOW_EN
        // Out-of-window write is suppressed and flagged.
        req = 4'b0010;
        wait_gnt(4'b0010, 10, "win_gnt");
        set_acc(1, 1'b0, 1'b1, 8'h05, 16'h5555);
        #1;
        check("win_wr_2_blocked", 32'(wr_2), 32'h0);
        tick();
        check("win_err", 32'(err), 32'h2);
        check("win_no_ack", 32'(ack), 32'h0);
        set_acc(1, 1'b0, 1'b1, 8'h25, 16'h6666);
        tick();
        check("win_ok_ack", 32'(ack), 32'h2);
        check("win_ok_err", 32'(err), 32'h0);
        clear_all();
        tick(); tick();
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares the peripheral-side port (port 2) of the dual-port RAM among up to NREQ peripheral cores. It replaces the single hard-wired peripheral on that port. Each requester holds a locked grant for a bounded burst of single-cycle accesses, so no requester can starve another. The CPU-side port (port 1) is untouched.

## Interface
- NREQ, 4: number of requesters, 2..8.
- MAX_BURST, 8: accesses per grant before forced release when others wait, 1..255.
- AW, 8: RAM address width.
- DW, 16: RAM data width.
- clk  in  1: system clock; all logic on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req  in  NREQ: per-requester request; level, held for the whole burst.
- rd_r  in  NREQ: per-requester read strobe; honoured only while the matching gnt bit is 1.
- wr_r  in  NREQ: per-requester write strobe; same rule as rd_r.
- addr_r  in  NREQ*AW: packed addresses; requester i uses slice [i*AW +: AW].
- wdata_r  in  NREQ*DW: packed write data; same slicing as addr_r.
- gnt  out  NREQ: one-hot grant, registered; reset 0.
- ack  out  NREQ: one-cycle pulse, registered; reset 0.
- rdata  out  DW: read data; valid on a read ack; reset 0.
- err  out  NREQ: one-cycle window-violation pulse; reset 0; constant 0 without the macro.
- addr_2  out  AW: RAM port-2 address; 0 when no access is issued.
- d_in_2  out  DW: RAM port-2 write data; 0 when no access is issued.
- rd_2  out  1: RAM port-2 read strobe; 0 in reset and while IDLE.
- wr_2  out  1: RAM port-2 write strobe; 0 in reset and while IDLE.
- d_out_2  in  DW: RAM port-2 read data; valid one cycle after rd_2.

## Operation
- FSM states: IDLE, GRANT. Registers: `ptr` (last granted index, reset NREQ-1), `cnt` (8-bit burst count).
- IDLE: if any req bit is 1, pick the first set bit searching from ptr+1 modulo NREQ. Register gnt one-hot, set ptr to that index, clear cnt, go to GRANT. If no req bit is 1, stay in IDLE with gnt=0.
- GRANT, winner w:
  - rd_2 = rd_r[w], wr_2 = wr_r[w]. If both are 1, the write wins and the read is dropped.
  - addr_2 and d_in_2 are the w slices, muxed combinationally.
  - cnt increments on each issued access.
- Release from GRANT to IDLE (gnt cleared next cycle) when either condition holds:
  - req[w] = 0, or
  - cnt reaches MAX_BURST on this access while any other req bit is 1.
- With no competitor, the burst is unlimited. cnt saturates at MAX_BURST.
- Ack: ack[w] pulses in the cycle after each issued access. For a read, rdata = d_out_2 in that same cycle. rdata holds its value between reads.
- Strobes from non-granted requesters are ignored; no ack is produced for them.
- Reset mid-burst: all outputs go to 0 immediately (asynchronous). An in-flight ack is lost. ptr returns to NREQ-1.

## Timing
- Arbitration to first access: req rises at cycle t (seen in IDLE), gnt at t+1, first access can issue at t+1, ack at t+2.
- Throughput inside a burst: one access per cycle.
- Handover: one IDLE bubble cycle between bursts. The next gnt appears 2 cycles after the last access of the previous burst.
- Simultaneous requests in IDLE: the round-robin order from ptr+1 decides the winner.
- req dropping in the same cycle as an access: that access issues and acks; the grant is then released.

## Configuration
- DPRAM_ARB_WINDOW_EN defined: requester i may access only addresses whose top 3 bits equal i, i.e. a 32-word window each. This limits window mode to NREQ ≤ 8.
  - An out-of-window access is suppressed: rd_2 = wr_2 = 0.
  - err[i] pulses in the following cycle instead of ack[i].
  - The suppressed access still counts toward cnt.
- DPRAM_ARB_WINDOW_EN undefined: no address check, err tied to 0.

## Structure
- Shared package `dpram_arb_pkg`: state encoding (IDLE = 0, GRANT = 1) and the window-index width constant (3).
- Sub-module `rr_pick`: combinational round-robin priority picker with inputs req and ptr and a one-hot output. Reusable elsewhere.
- The top module holds the FSM, counter, datapath mux and ack/err registers.

## Test plan
- Single requester: req[1] with writes of 0xBEEF to 0x10 then 0xCAFE to 0x11, then a read of 0x10 → gnt = 0b0010 one cycle after req; acks on consecutive cycles; the read ack shows rdata = 0xBEEF.
- Simultaneous req = 0b1111 from reset → grants in order 0, 1, 2, 3 (ptr reset = 3), each burst separated by one IDLE cycle.
- Burst limit: MAX_BURST = 8, requester 0 streams reads while req[2] is held → exactly 8 acks to requester 0, then IDLE, then gnt = 0b0100. A lone requester streaming 20 reads gets 20 acks with no release.
- Simultaneous rd_r and wr_r on the granted requester at address 0x20 with data 0x1234 → only the write is issued; a later read of 0x20 returns 0x1234.
- Assert rst_n low mid-burst → gnt, ack, rd_2 and wr_2 go to 0 without a clock edge. After release, req = 0b0011 is granted to 0 first.
- With DPRAM_ARB_WINDOW_EN: requester 1 writes to 0x05 → wr_2 stays 0, err[1] pulses, no ack. A write to 0x25 acks normally.
